// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: four 32-bit registers, one-byte TX holding register
// in front of the shifter, RX FIFO and a registered level interrupt.
module uart_periph #(
  parameter logic [15:0] DEFAULT_DIV  = 16'd103,
  parameter int          RX_FIFO_BITS = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int                    DEPTH       = 1 << RX_FIFO_BITS;
  localparam logic [RX_FIFO_BITS:0] LP_FULL     = (RX_FIFO_BITS+1)'(DEPTH);
  localparam logic [RX_FIFO_BITS:0] LP_CNT_ONE  = (RX_FIFO_BITS+1)'(1);
  localparam logic [RX_FIFO_BITS-1:0] LP_PTR_ONE = (RX_FIFO_BITS)'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // bus and register file
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_irq;
  logic [15:0] r_div;
  logic [1:0]  r_ctrl;
  logic        r_ovr;
  logic        r_ferr;
  logic        r_hold_full;
  logic [7:0]  r_hold;

  // TX path
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [15:0] r_tx_div, w_tx_div_nxt;
  logic [7:0]  r_tx_sh, w_tx_sh_nxt;
  logic [2:0]  r_tx_bit, w_tx_bit_nxt;
  logic        r_tx, w_tx_nxt;
  logic        w_tx_take;

  // RX path
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [15:0] r_rx_div, w_rx_div_nxt;
  logic [7:0]  r_rx_sh, w_rx_sh_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic        w_rx_push, w_rx_ferr_set;
  logic        r_push;
  logic [7:0]  r_push_data;
  logic [16:0] w_rx_half17;
  logic [15:0] w_rx_half;
  logic        w_rx_src;

  // RX FIFO
  logic [7:0]              r_mem [DEPTH];
  logic [RX_FIFO_BITS-1:0] r_wptr, r_rptr;
  logic [RX_FIFO_BITS:0]   r_count;
  logic                    w_fifo_ne, w_fifo_full, w_pop, w_push_ok, w_ovr_set;

  logic        w_acc, w_rd, w_wr, w_hold_load, w_tx_idle;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_unused = ^{wdata[31:16], wstrb[3:2]};

  assign w_acc       = sel & ~r_ready;
  assign w_rd        = w_acc & (wstrb == 4'h0);
  assign w_wr        = w_acc & (wstrb != 4'h0);
  assign w_hold_load = w_wr & (addr == 2'd0) & wstrb[0] & ~r_hold_full;
  assign w_tx_idle   = ~r_hold_full & (r_tx_state == TX_IDLE);

  assign w_fifo_ne   = (r_count != '0);
  assign w_fifo_full = (r_count == LP_FULL);
  assign w_pop       = w_rd & (addr == 2'd0) & w_fifo_ne;
  // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
  assign w_push_ok   = r_push & (~w_fifo_full | w_pop);
  assign w_ovr_set   = r_push & w_fifo_full & ~w_pop;

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign irq   = r_irq;
  assign tx    = r_tx | r_ctrl[1];

  always_comb begin
    w_rd_val = 32'h0;
    case (addr)
      2'd0: w_rd_val = w_fifo_ne ? {24'h0, r_mem[r_rptr]} : 32'h0;
      2'd1: w_rd_val = {27'h0, r_ferr, r_ovr, w_tx_idle, ~r_hold_full, w_fifo_ne};
      2'd2: w_rd_val = {16'h0, r_div};
      default: w_rd_val = {30'h0, r_ctrl};
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ready     <= 1'b0;
      r_rdata     <= 32'h0;
      r_irq       <= 1'b0;
      r_div       <= DEFAULT_DIV;
      r_ctrl      <= 2'b00;
      r_ovr       <= 1'b0;
      r_ferr      <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold      <= 8'h0;
    end else begin
      r_ready <= w_acc;
      r_irq   <= r_ctrl[0] & w_fifo_ne;
      if (w_acc) r_rdata <= w_rd ? w_rd_val : 32'h0;
      if (w_wr && addr == 2'd2) begin
        if (wstrb[0]) r_div[7:0]  <= wdata[7:0];
        if (wstrb[1]) r_div[15:8] <= wdata[15:8];
      end
      if (w_wr && addr == 2'd3 && wstrb[0]) r_ctrl <= wdata[1:0];
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (w_wr && addr == 2'd1 && wstrb[0] && wdata[3]) r_ovr <= 1'b0;
      if (w_rx_ferr_set) r_ferr <= 1'b1;
      else if (w_wr && addr == 2'd1 && wstrb[0] && wdata[4]) r_ferr <= 1'b0;
      if (w_tx_take) r_hold_full <= 1'b0;
      else if (w_hold_load) begin
        r_hold_full <= 1'b1;
        r_hold      <= wdata[7:0];
      end
    end
  end

  // TX: the divisor is latched at frame start so DIVISOR writes never split a frame
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt - 16'd1;
    w_tx_div_nxt   = r_tx_div;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_nxt       = r_tx;
    w_tx_take      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt     = 1'b1;
        w_tx_cnt_nxt = r_tx_cnt;
        if (r_hold_full) begin
          w_tx_take      = 1'b1;
          w_tx_sh_nxt    = r_hold;
          w_tx_div_nxt   = r_div;
          w_tx_cnt_nxt   = r_div;
          w_tx_nxt       = 1'b0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = r_tx_div;
          w_tx_bit_nxt   = 3'd0;
          w_tx_nxt       = r_tx_sh[0];
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_cnt_nxt = r_tx_div;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_bit_nxt = r_tx_bit + 3'd1;
            w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
            w_tx_nxt     = r_tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == 16'd0) begin
          if (r_hold_full) begin
            w_tx_take      = 1'b1;
            w_tx_sh_nxt    = r_hold;
            w_tx_div_nxt   = r_div;
            w_tx_cnt_nxt   = r_div;
            w_tx_nxt       = 1'b0;
            w_tx_state_nxt = TX_START;
          end else begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_nxt       = 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'h0;
      r_tx_div   <= 16'h0;
      r_tx_sh    <= 8'h0;
      r_tx_bit   <= 3'd0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_div   <= w_tx_div_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign w_rx_src    = r_ctrl[1] ? r_tx : rx;
  assign w_rx_half17 = {1'b0, r_div} + 17'd1;
  assign w_rx_half   = w_rx_half17[16:1] - 16'd1;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt - 16'd1;
    w_rx_div_nxt   = r_rx_div;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_push      = 1'b0;
    w_rx_ferr_set  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = w_rx_half;
          w_rx_div_nxt   = r_div;
        end
      end
      RX_START: begin
        if (r_rx_cnt == 16'd0) begin
          w_rx_cnt_nxt = r_rx_div;
          w_rx_bit_nxt = 3'd0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == 16'd0) begin
          w_rx_cnt_nxt = r_rx_div;
          w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else w_rx_bit_nxt = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == 16'd0) begin
          if (r_rx_s2) begin
            w_rx_push      = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_ferr_set  = 1'b1;
            w_rx_state_nxt = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= 16'h0;
      r_rx_div    <= 16'h0;
      r_rx_sh     <= 8'h0;
      r_rx_bit    <= 3'd0;
      r_push      <= 1'b0;
      r_push_data <= 8'h0;
    end else begin
      r_rx_s1    <= w_rx_src;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_div   <= w_rx_div_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_push     <= w_rx_push;
      if (w_rx_push) r_push_data <= r_rx_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_push_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + LP_PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + LP_PTR_ONE;
      if (w_push_ok && !w_pop) r_count <= r_count + LP_CNT_ONE;
      else if (!w_push_ok && w_pop) r_count <= r_count - LP_CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: bus reads and TX frames are checked by
// monitors against expectations queued when the stimulus is issued.
module tb_uart_periph;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  uart_periph #(.DEFAULT_DIV(16'd103), .RX_FIFO_BITS(3)) dut (
    .clk(clk), .nreset(nreset), .sel(sel), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .ready(ready), .rx(rx), .tx(tx), .irq(irq)
  );

  typedef struct {bit chk; logic [31:0] exp; string name;} bus_exp_t;
  typedef struct {logic [7:0] b; bit b2b;} tx_exp_t;

  bus_exp_t bus_q[$];
  tx_exp_t  tx_q[$];
  bus_exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int tb_div = 3;
  bit tx_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit chk, input logic [31:0] exp, input string name);
    bus_exp_t e;
    int n;
    e.chk = chk; e.exp = exp; e.name = name;
    bus_q.push_back(e);
    addr = a; wstrb = s; wdata = d; sel = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 20);
    if (!ready) check({name, "_ready_timeout"}, 32'(ready), 32'd1);
    sel = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus(a, 4'h0, 32'h0, 1'b1, exp, name);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(a, 4'hF, d, 1'b0, 32'h0, "write");
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      step(4);
    end
    rx = 1'b1;
    step(4);
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || tx_busy) && n < 3000) begin step(1); n++; end
    if (n >= 3000) check("tx_done_timeout", 32'(tx_q.size()), 32'd0);
  endtask

  // bus monitor
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (bus_q.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.chk) check(mon_e.name, rdata, mon_e.exp);
      end
    end
  end

  // TX serial monitor: every bit must hold for exactly tb_div+1 clocks
  initial begin
    tx_exp_t te;
    logic [9:0] bits;
    logic seen;
    int n;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0) begin
        tx_busy = 1'b1;
        te = tx_q.pop_front();
        bits = {1'b1, te.b, 1'b0};
        if (!te.b2b) begin
          n = 0;
          while (tx === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 10; i++) begin
          seen = bits[i];
          for (int k = 0; k <= tb_div; k++) begin
            if (!(i == 0 && k == 0)) @(negedge clk);
            if (tx !== bits[i]) seen = tx;
          end
          check($sformatf("tx_frame_%02h_bit%0d", te.b, i), 32'(seen), 32'(bits[i]));
        end
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tx_exp_t te;
    int n;
    logic stuck;

    step(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    nreset = 1'b1;
    step(2);
    rd(2'd1, 32'h06, "status_reset");
    rd(2'd2, 32'd103, "divisor_reset");
    rd(2'd3, 32'h0, "ctrl_reset");
    rd(2'd0, 32'h0, "data_empty_reset");

    // single frame, DIVISOR=3
    wr(2'd2, 32'd3);
    rd(2'd2, 32'd3, "divisor_rw");
    te.b = 8'hA5; te.b2b = 1'b0; tx_q.push_back(te);
    wr(2'd0, 32'hA5);
    check("tx_high_in_ready_cycle", 32'(tx), 32'd1);
    step(1);
    check("tx_start_latency", 32'(tx), 32'd0);
    wait_tx_done();
    rd(2'd1, 32'h06, "status_tx_idle_after_a5");

    // back-to-back frames, third write dropped
    te.b = 8'h11; te.b2b = 1'b0; tx_q.push_back(te);
    te.b = 8'h22; te.b2b = 1'b1; tx_q.push_back(te);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    rd(2'd1, 32'h00, "status_hold_full_busy");
    wait_tx_done();
    stuck = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) stuck = 1'b0;
      step(1);
    end
    check("no_frame_after_dropped_write", 32'(stuck), 32'd1);

    // loopback with irq
    wr(2'd3, 32'h3);
    wr(2'd0, 32'h3C);
    n = 0;
    while (irq !== 1'b1 && n < 1000) begin step(1); n++; end
    check("loopback_irq_rise", 32'(irq), 32'd1);
    check("loopback_tx_pin_high", 32'(tx), 32'd1);
    rd(2'd0, 32'h3C, "loopback_data");
    check("irq_still_high_ready_cycle", 32'(irq), 32'd1);
    step(1);
    check("irq_fall_after_pop", 32'(irq), 32'd0);
    rd(2'd0, 32'h0, "loopback_data_empty");
    wr(2'd3, 32'h0);
    step(4);

    // overrun: 9 frames into 8-deep FIFO
    for (int i = 0; i < 9; i++) send_rx(8'h30 + 8'(i), 1'b1);
    rd(2'd1, 32'h0F, "status_overrun");
    for (int i = 0; i < 8; i++) rd(2'd0, 32'h30 + 32'(i), $sformatf("fifo_order_%0d", i));
    rd(2'd1, 32'h0E, "status_drained_ovr");
    bus(2'd1, 4'h1, 32'h8, 1'b0, 32'h0, "clear_ovr");
    rd(2'd1, 32'h06, "status_ovr_cleared");

    // framing error and glitch
    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b0);
    rd(2'd1, 32'h17, "status_frame_err");
    rd(2'd0, 32'h5A, "fifo_unchanged_by_bad_frame");
    rd(2'd0, 32'h0, "fifo_empty_after_bad_frame");
    bus(2'd1, 4'h1, 32'h10, 1'b0, 32'h0, "clear_ferr");
    rd(2'd1, 32'h06, "status_ferr_cleared");
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(20);
    rd(2'd1, 32'h06, "status_after_glitch");

    // async reset mid-frame
    wr(2'd0, 32'h00);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin step(1); n++; end
    check("tx_started_before_reset", 32'(tx), 32'd0);
    step(6);
    #2 nreset = 1'b0;
    #1 check("tx_high_on_async_reset", 32'(tx), 32'd1);
    step(2);
    nreset = 1'b1;
    step(2);
    rd(2'd2, 32'd103, "divisor_after_reset");
    rd(2'd1, 32'h06, "status_after_reset");

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART peripheral for the PicoRV32 SoC. It sits on the CPU's port-select region, driving the top-level `tx` pin and sampling `rx`. Software sees four 32-bit registers. The block provides a one-byte TX holding register behind the shift register, an RX FIFO, and a level interrupt for the CPU `irq` vector.

## Interface
- `DEFAULT_DIV`, 16'd103, reset value of DIVISOR; bit period = DIVISOR+1 clocks
- `RX_FIFO_BITS`, 3, RX FIFO depth = 2^RX_FIFO_BITS bytes
- `clk` in 1: system clock
- `nreset` in 1: reset, asynchronous, active-low
- `sel` in 1: mem_valid qualified by the port-region address decode
- `addr` in 2: word offset, taken from mem_la_addr[3:2]
- `wstrb` in 4: byte write strobes; 0 = read
- `wdata` in 32: write data
- `rdata` out 32: registered read data
- `ready` out 1: registered access-done strobe
- `rx` in 1: serial input, asynchronous
- `tx` out 1: serial output
- `irq` out 1: level interrupt

## Operation
- Register map (addr):
  - 0 DATA: write with wstrb[0] loads the TX holding register. Read pops the RX FIFO; returns {24'h0, byte}, or 0 when the FIFO is empty (no pop).
  - 1 STATUS (read): bit0 rx_not_empty, bit1 tx_hold_empty, bit2 tx_idle (holding empty and shifter idle), bit3 rx_overrun, bit4 rx_frame_err, bits31:5 = 0. Write: a 1 in bit3 or bit4 clears that sticky flag.
  - 2 DIVISOR: [15:0] read/write, bits31:16 read 0. Write takes effect at the next frame start.
  - 3 CTRL: bit0 rx_irq_en, bit1 loopback (rx path fed from internal tx; `tx` pin held 1). Read/write.
- Bus access: performed in the cycle where sel=1 and ready=0. Next cycle: ready=1 and rdata valid. ready is then forced 0 for one cycle, so each access takes effect exactly once.
- TX write when holding is full: the write is dropped and ready is still given. Software polls tx_hold_empty.
- TX FSM: IDLE → START → DATA(8, LSB first) → STOP → IDLE.
  - In IDLE with holding full: move the byte to the shifter, mark holding empty, and drive start on the next clock.
  - Holding refilled during a frame: the next frame starts in the clock after STOP ends. No idle gap.
- RX path:
  - 2-FF synchronizer on rx.
  - RX FSM: IDLE → START → DATA → STOP.
  - IDLE: a 1→0 transition starts a half-period count of (DIVISOR+1)>>1 clocks.
  - START: sampled high → false start, return to IDLE.
  - DATA and STOP: sampled at full bit periods after the start sample.
  - STOP sampled 0: byte discarded, rx_frame_err set, FSM waits for rx=1 before IDLE.
  - STOP sampled 1: byte pushed. If the FIFO is full, the byte is dropped and rx_overrun set.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged. On a full FIFO, the pop frees space first and the push succeeds.
- irq = rx_irq_en & rx_not_empty, registered.

## Timing
- Reset values:
  - tx=1, rdata=0, ready=0, irq=0
  - FIFO empty, flags 0, CTRL=0, DIVISOR=DEFAULT_DIV
  - both FSMs IDLE
- Reset asserted mid-frame: tx goes to 1 immediately (async). The partial RX byte is lost.
- Bus latency: 1 clock from sel to ready. Status reflects state at the access cycle.
- TX: `tx` falls 1 clock after the DATA write ready cycle when idle. Each bit lasts exactly DIVISOR+1 clocks. Frame = 10×(DIVISOR+1) clocks.
- RX: byte visible in STATUS.bit0 2 clocks after the stop-bit sample. irq follows 1 clock later.
- Bit counters are 16-bit; DIVISOR=0 means 1 clock per bit (legal for TX; RX requires DIVISOR≥3).

## Test plan
- Reset → tx=1, STATUS read = 0x06, DIVISOR read = DEFAULT_DIV, irq=0.
- DIVISOR=3, write DATA 0xA5 → tx bit pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total. tx_idle reads 1 afterwards.
- DIVISOR=3, write 0x11 then, while busy, 0x22 → back-to-back frames with no gap. A third write while holding is full is dropped.
- Loopback, rx_irq_en=1, send 0x3C → irq rises, DATA read = 0x3C, irq falls 1 clock after the pop. A second DATA read returns 0.
- Drive 9 frames into an 8-deep FIFO without reads → bit3 overrun=1, first 8 bytes read back in order, write 0x8 to STATUS clears the flag.
- Frame with stop bit 0 → rx_frame_err=1, FIFO unchanged. A 1-clock low glitch on rx produces no byte.
